// File: rtl/pu_riscv_id_fetch_queue.sv
// IF->ID instruction queue plus decode-stage register.
// Buffers up to DEPTH fetched parcels so fetch keeps running while decode stalls,
// and presents one entry per cycle to decode (a NOP bubble when nothing is available).
//
// Ports:
//   rstn, clk                         async active-low reset, rising-edge clock
//   if_valid / if_ready               fetch handshake; if_ready = queue not full
//   if_pc, if_instr, if_bp_predict,
//   if_exception                      offered parcel
//   id_stall, du_stall                decode hold
//   bu_flush, st_flush, du_flush      discard queue, offered parcel and decode entry
//   id_pc, id_instr, id_bubble,
//   id_bp_predict, id_exception       registered decode entry
//   q_count                           entries held in the queue (decode register excluded)
module pu_riscv_id_fetch_queue #(
  parameter int unsigned     XLEN           = 64,
  parameter int unsigned     ILEN           = 32,
  parameter int unsigned     EXCEPTION_SIZE = 16,
  parameter int unsigned     DEPTH          = 4,
  parameter logic [XLEN-1:0] PC_INIT        = 'h200,
  parameter logic [ILEN-1:0] INSTR_NOP      = 'h00000013
) (
  input  logic                      rstn,
  input  logic                      clk,

  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [XLEN-1:0]           if_pc,
  input  logic [ILEN-1:0]           if_instr,
  input  logic [1:0]                if_bp_predict,
  input  logic [EXCEPTION_SIZE-1:0] if_exception,

  input  logic                      id_stall,
  input  logic                      du_stall,
  input  logic                      bu_flush,
  input  logic                      st_flush,
  input  logic                      du_flush,

  output logic [XLEN-1:0]           id_pc,
  output logic [ILEN-1:0]           id_instr,
  output logic                      id_bubble,
  output logic [1:0]                id_bp_predict,
  output logic [EXCEPTION_SIZE-1:0] id_exception,
  output logic [$clog2(DEPTH):0]    q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]           pc_mem  [DEPTH];
  logic [ILEN-1:0]           ins_mem [DEPTH];
  logic [1:0]                bp_mem  [DEPTH];
  logic [EXCEPTION_SIZE-1:0] exc_mem [DEPTH];

  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic flush, stall, full, empty, push, advance, pop, bypass, wr;

  assign flush    = bu_flush | st_flush | du_flush;
  assign stall    = id_stall | du_stall;
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign if_ready = ~full;
  assign push     = if_valid & if_ready & ~flush;
  assign advance  = ~stall & ~flush;
  assign pop      = advance & ~empty;
  // An empty queue hands the parcel straight to decode instead of storing it.
  assign bypass   = advance & empty & push;
  assign wr       = push & ~bypass;
  assign q_count  = count_q;

  // Queue storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[wr_ptr_q]  <= if_pc;
      ins_mem[wr_ptr_q] <= if_instr;
      bp_mem[wr_ptr_q]  <= if_bp_predict;
      exc_mem[wr_ptr_q] <= if_exception;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(wr) - CW'(pop);
    end
  end

  // Decode register; id_pc deliberately keeps its last value across bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_pc         <= PC_INIT;
      id_instr      <= INSTR_NOP;
      id_bubble     <= 1'b1;
      id_bp_predict <= '0;
      id_exception  <= '0;
    end else if (flush) begin
      id_instr      <= INSTR_NOP;
      id_bubble     <= 1'b1;
      id_bp_predict <= '0;
      id_exception  <= '0;
    end else if (advance) begin
      if (!empty) begin
        id_pc         <= pc_mem[rd_ptr_q];
        id_instr      <= ins_mem[rd_ptr_q];
        id_bubble     <= 1'b0;
        id_bp_predict <= bp_mem[rd_ptr_q];
        id_exception  <= exc_mem[rd_ptr_q];
      end else if (push) begin
        id_pc         <= if_pc;
        id_instr      <= if_instr;
        id_bubble     <= 1'b0;
        id_bp_predict <= if_bp_predict;
        id_exception  <= if_exception;
      end else begin
        id_instr      <= INSTR_NOP;
        id_bubble     <= 1'b1;
        id_bp_predict <= '0;
        id_exception  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pu_riscv_id_fetch_queue.sv
module tb_pu_riscv_id_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        rstn, clk;
  logic        if_valid, if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [1:0]  if_bp_predict;
  logic [15:0] if_exception;
  logic        id_stall, du_stall, bu_flush, st_flush, du_flush;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        id_bubble;
  logic [1:0]  id_bp_predict;
  logic [15:0] id_exception;
  logic [2:0]  q_count;

  int checks = 0;
  int fails  = 0;

  pu_riscv_id_fetch_queue dut (
    .rstn          (rstn),
    .clk           (clk),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_bp_predict (if_bp_predict),
    .if_exception  (if_exception),
    .id_stall      (id_stall),
    .du_stall      (du_stall),
    .bu_flush      (bu_flush),
    .st_flush      (st_flush),
    .du_flush      (du_flush),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_bubble     (id_bubble),
    .id_bp_predict (id_bp_predict),
    .id_exception  (id_exception),
    .q_count       (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] ins, input logic [1:0] bp,
                       input logic [15:0] exc);
    if_valid      = 1'b1;
    if_pc         = pc;
    if_instr      = ins;
    if_bp_predict = bp;
    if_exception  = exc;
  endtask

  task automatic test_reset();
    rstn = 1'b0; if_valid = 0; if_pc = 0; if_instr = 0; if_bp_predict = 0; if_exception = 0;
    id_stall = 0; du_stall = 0; bu_flush = 0; st_flush = 0; du_flush = 0;
    step(); step();
    checks++; if (id_bubble !== 1'b1) begin fails++; $display("FAIL por_bubble got %b exp 1", id_bubble); end
    checks++; if (id_pc !== 64'h200) begin fails++; $display("FAIL por_pc got %h exp 200", id_pc); end
    checks++; if (id_instr !== NOP) begin fails++; $display("FAIL por_instr got %h exp %h", id_instr, NOP); end
    checks++; if (id_exception !== 16'h0 || id_bp_predict !== 2'b0) begin
      fails++; $display("FAIL por_exc_bp got %h/%b exp 0/0", id_exception, id_bp_predict); end
    rstn = 1'b1;
    step();
    // Queue three parcels under stall, then reset mid-stream.
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      offer(64'h500 + 64'(4 * i), 32'h11, 2'b01, 16'h0);
      step();
    end
    if_valid = 0;
    checks++; if (q_count !== 3'd3) begin fails++; $display("FAIL rst_pre_count got %0d exp 3", q_count); end
    rstn = 1'b0;
    #1;
    checks++; if (id_bubble !== 1'b1) begin fails++; $display("FAIL rst_bubble got %b exp 1", id_bubble); end
    checks++; if (id_pc !== 64'h200) begin fails++; $display("FAIL rst_pc got %h exp 200", id_pc); end
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", q_count); end
    checks++; if (if_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", if_ready); end
    id_stall = 0;
    step();
    rstn = 1'b1;
    step(); step();
    checks++; if (id_bubble !== 1'b1 || q_count !== 3'd0) begin
      fails++; $display("FAIL rst_no_survivor got bubble %b count %0d exp 1/0", id_bubble, q_count); end
  endtask

  task automatic test_bypass();
    offer(64'h1000, 32'h00500093, 2'b10, 16'h0);
    step();
    if_valid = 0;
    checks++; if (id_pc !== 64'h1000) begin fails++; $display("FAIL byp_pc got %h exp 1000", id_pc); end
    checks++; if (id_instr !== 32'h00500093) begin fails++; $display("FAIL byp_instr got %h exp 00500093", id_instr); end
    checks++; if (id_bubble !== 1'b0) begin fails++; $display("FAIL byp_bubble got %b exp 0", id_bubble); end
    checks++; if (id_bp_predict !== 2'b10) begin fails++; $display("FAIL byp_bp got %b exp 10", id_bp_predict); end
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL byp_count got %0d exp 0", q_count); end
    step();
    checks++; if (id_bubble !== 1'b1 || id_instr !== NOP || id_bp_predict !== 2'b0) begin
      fails++; $display("FAIL empty_bubble got %b/%h/%b exp 1/%h/0", id_bubble, id_instr, id_bp_predict, NOP); end
    checks++; if (id_pc !== 64'h1000) begin fails++; $display("FAIL empty_pc_hold got %h exp 1000", id_pc); end
  endtask

  task automatic test_fill_stall();
    id_stall = 1;
    for (int i = 0; i < 5; i++) begin
      offer(64'h100 + 64'(4 * i), 32'hA000_0000 | 32'(i), 2'(i), 16'h0);
      #1;
      checks++; if (if_ready !== (i < 4)) begin
        fails++; $display("FAIL fill_ready_%0d got %b exp %b", i, if_ready, (i < 4)); end
      step();
    end
    if_valid = 0;
    checks++; if (q_count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d exp 4", q_count); end
    checks++; if (if_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %b exp 0", if_ready); end
    checks++; if (id_pc !== 64'h1000 || id_bubble !== 1'b1) begin
      fails++; $display("FAIL fill_hold got %h/%b exp 1000/1", id_pc, id_bubble); end
    id_stall = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (id_pc !== 64'h100 + 64'(4 * i) || id_instr !== (32'hA000_0000 | 32'(i))
                    || id_bubble !== 1'b0 || id_bp_predict !== 2'(i)) begin
        fails++; $display("FAIL drain_%0d got %h/%h/%b exp %h/%h/0", i, id_pc, id_instr, id_bubble,
                          64'h100 + 64'(4 * i), 32'hA000_0000 | 32'(i)); end
      checks++; if (q_count !== 3'(3 - i)) begin
        fails++; $display("FAIL drain_count_%0d got %0d exp %0d", i, q_count, 3 - i); end
    end
    step();
    checks++; if (id_bubble !== 1'b1) begin fails++; $display("FAIL drain_end got %b exp 1", id_bubble); end
  endtask

  task automatic test_flush();
    id_stall = 1;
    for (int i = 0; i < 3; i++) begin
      offer(64'h2000 + 64'(4 * i), 32'h22, 2'b11, 16'h4);
      step();
    end
    checks++; if (q_count !== 3'd3) begin fails++; $display("FAIL fl_pre_count got %0d exp 3", q_count); end
    offer(64'hDEAD0, 32'hBAD, 2'b11, 16'h8);
    bu_flush = 1;
    step();
    bu_flush = 0; id_stall = 0; if_valid = 0;
    checks++; if (q_count !== 3'd0) begin fails++; $display("FAIL fl_count got %0d exp 0", q_count); end
    checks++; if (id_bubble !== 1'b1 || id_instr !== NOP || id_exception !== 16'h0) begin
      fails++; $display("FAIL fl_bubble got %b/%h/%h exp 1/%h/0", id_bubble, id_instr, id_exception, NOP); end
    // Last valid decode entry was pc 0x10C from the fill test; flush must not move id_pc.
    checks++; if (id_pc !== 64'h10C) begin fails++; $display("FAIL fl_pc_hold got %h exp 10c", id_pc); end
    step();
    checks++; if (id_bubble !== 1'b1 || id_pc !== 64'h10C) begin
      fails++; $display("FAIL fl_dropped got %b/%h exp 1/10c", id_bubble, id_pc); end
    // Combined st/du flush with a stalled queue entry.
    id_stall = 1;
    offer(64'h2100, 32'h33, 2'b00, 16'h0);
    step();
    if_valid = 0; st_flush = 1; du_flush = 1;
    step();
    st_flush = 0; du_flush = 0; id_stall = 0;
    step();
    checks++; if (q_count !== 3'd0 || id_bubble !== 1'b1) begin
      fails++; $display("FAIL multi_flush got %0d/%b exp 0/1", q_count, id_bubble); end
  endtask

  task automatic test_wrap_exception();
    for (int k = 0; k < 14; k++) begin
      id_stall = (k < 3);
      if (k < 10) offer(64'h8000 + 64'(4 * k), 32'h0000_1000 + 32'(k), 2'(k),
                        (k == 6) ? 16'h2 : 16'h0);
      else if_valid = 0;
      step();
      if (k == 2) begin
        checks++; if (q_count !== 3'd3) begin fails++; $display("FAIL wr_count got %0d exp 3", q_count); end
      end
      if (k >= 3 && k <= 12) begin
        checks++; if (id_pc !== 64'h8000 + 64'(4 * (k - 3)) || id_bubble !== 1'b0
                      || id_instr !== 32'h0000_1000 + 32'(k - 3) || id_bp_predict !== 2'(k - 3)) begin
          fails++; $display("FAIL wr_order_%0d got %h/%b/%h exp %h/0/%h", k - 3, id_pc, id_bubble,
                            id_instr, 64'h8000 + 64'(4 * (k - 3)), 32'h0000_1000 + 32'(k - 3)); end
        checks++; if (id_exception !== ((k - 3 == 6) ? 16'h2 : 16'h0)) begin
          fails++; $display("FAIL wr_exc_%0d got %h exp %h", k - 3, id_exception,
                            (k - 3 == 6) ? 16'h2 : 16'h0); end
      end
      if (k == 13) begin
        checks++; if (id_bubble !== 1'b1 || q_count !== 3'd0) begin
          fails++; $display("FAIL wr_end got %b/%0d exp 1/0", id_bubble, q_count); end
      end
    end
  endtask

  task automatic test_full_pop();
    id_stall = 1;
    for (int i = 0; i < 4; i++) begin
      offer(64'h3000 + 64'(4 * i), 32'h44, 2'b00, 16'h0);
      step();
    end
    id_stall = 0;
    offer(64'h4000, 32'h55, 2'b01, 16'h0);
    #1;
    checks++; if (if_ready !== 1'b0) begin fails++; $display("FAIL fp_ready_full got %b exp 0", if_ready); end
    step();
    checks++; if (q_count !== 3'd3) begin fails++; $display("FAIL fp_count got %0d exp 3", q_count); end
    checks++; if (if_ready !== 1'b1) begin fails++; $display("FAIL fp_ready got %b exp 1", if_ready); end
    checks++; if (id_pc !== 64'h3000) begin fails++; $display("FAIL fp_head got %h exp 3000", id_pc); end
    step();
    if_valid = 0;
    checks++; if (q_count !== 3'd3 || id_pc !== 64'h3004) begin
      fails++; $display("FAIL fp_pushpop got %0d/%h exp 3/3004", q_count, id_pc); end
    step(); step(); step();
    checks++; if (id_pc !== 64'h4000 || id_instr !== 32'h55 || id_bubble !== 1'b0) begin
      fails++; $display("FAIL fp_last got %h/%h/%b exp 4000/55/0", id_pc, id_instr, id_bubble); end
    step();
    checks++; if (id_bubble !== 1'b1 || q_count !== 3'd0) begin
      fails++; $display("FAIL fp_dup got %b/%0d exp 1/0", id_bubble, q_count); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_stall();
    test_flush();
    test_wrap_exception();
    test_full_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
